timer_borrow_ctrl: RTL

- Initiator end of the digit-timer borrow chain.
- Turns the player's reconfigure button into the two-press configuration sequence the digit chain expects.
- Generates one borrow request per prescaled tick into the least-significant digit, and detects expiry from the digit counts or the chain's no-borrow flag.
- Sits between the button/debounce logic and the cascaded countdown digits; its expired/defused outputs drive the bomb game FSM.

---
 rtl/timer_borrow_ctrl_if.sv | 26 ++
 rtl/timer_borrow_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/timer_borrow_ctrl_if.sv
// rtl/timer_borrow_ctrl_if.sv - signal bundle between the borrow-chain initiator and the button/digit/game side
interface timer_borrow_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    reconfigBtn;
    logic                    pauseIn;
    logic                    defuseIn;
    logic [4*NUM_DIGITS-1:0] timerCounts;
    logic                    noBorrowIn;
    logic                    timerReconfig;
    logic                    borrowDown;
    logic                    running;
    logic                    expired;
    logic                    defused;
    logic [2:0]              state;

    modport master (
        input  reconfigBtn, pauseIn, defuseIn, timerCounts, noBorrowIn,
        output timerReconfig, borrowDown, running, expired, defused, state
    );

    modport slave (
        output reconfigBtn, pauseIn, defuseIn, timerCounts, noBorrowIn,
        input  timerReconfig, borrowDown, running, expired, defused, state
    );
endinterface

// File: rtl/timer_borrow_ctrl.sv
// rtl/timer_borrow_ctrl.sv - borrow-chain initiator: two-press reconfig sequencing, tick borrows, expiry/defuse
module timer_borrow_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    timer_borrow_ctrl_if.master bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOADED  = 3'd1,
        ARMED   = 3'd2,
        RUN     = 3'd3,
        EXPIRED = 3'd4,
        DEFUSED = 3'd5
    } state_t;

    state_t        stateQ;
    state_t        stateD;
    logic [PW-1:0] prescQ;
    logic [PW-1:0] prescD;
    logic          borrowQ;
    logic          borrowD;
    logic          btnQ;
    logic          reconfigQ;
    logic          btnEdge;
    logic          countsZero;

    assign btnEdge = bus.reconfigBtn & ~btnQ;

    always_comb begin
        countsZero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.timerCounts[4*i +: 4] != 4'd0) begin
                countsZero = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btnQ      <= 1'b0;
            reconfigQ <= 1'b0;
        end else begin
            btnQ      <= bus.reconfigBtn;
            reconfigQ <= btnEdge;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ  <= IDLE;
            prescQ  <= '0;
            borrowQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            prescQ  <= prescD;
            borrowQ <= borrowD;
        end
    end

    // A borrow is only requested from the plain counting branch, so any exit from RUN suppresses it.
    always_comb begin
        stateD  = stateQ;
        prescD  = prescQ;
        borrowD = 1'b0;
        case (stateQ)
            IDLE: begin
                if (btnEdge) stateD = LOADED;
            end
            LOADED: begin
                if (btnEdge) stateD = ARMED;
            end
            ARMED: begin
                stateD = RUN;
                prescD = '0;
            end
            RUN: begin
                if (btnEdge) begin
                    stateD = LOADED;
                    prescD = '0;
                end else if (countsZero || bus.noBorrowIn) begin
                    stateD = EXPIRED;
                end else if (bus.defuseIn) begin
                    stateD = DEFUSED;
                end else if (!bus.pauseIn) begin
                    if (prescQ == PRESC_LAST) begin
                        prescD  = '0;
                        borrowD = 1'b1;
                    end else begin
                        prescD = prescQ + PW'(1);
                    end
                end
            end
            EXPIRED, DEFUSED: begin
                if (btnEdge) stateD = LOADED;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    assign bus.timerReconfig = reconfigQ;
    assign bus.borrowDown    = borrowQ;
    assign bus.running       = (stateQ == RUN);
    assign bus.expired       = (stateQ == EXPIRED);
    assign bus.defused       = (stateQ == DEFUSED);
    assign bus.state         = stateQ;
endmodule
